// File: rtl/sha_last_digest_checker.sv
// Last-pass SHA-256 digest checker: adds the IV, compares the
// little-endian digest against a target and captures hits.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   instate        final working state, word a in [255:224] .. h in [31:0]
//   valid_i        instate valid this cycle
//   newblock_i     restart nonce count (tag 0) for this hash
//   target_i       hash passes when digest_le <= target_i
//   hit_ack_i      consumer accepts the captured hit
//   checked_o      one-cycle pulse per completed compare
//   hit_valid_o    capture register holds a hit
//   hit_nonce_o    nonce of the held hit
//   hit_digest_o   digest words 0..7 of the held hit, word 0 in MSBs
//   missed_o       saturating count of hits dropped while full
module sha_last_digest_checker #(
    parameter int NONCE_W = 32,
    parameter int MISS_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [255:0]       instate,
    input  logic               valid_i,
    input  logic               newblock_i,
    input  logic [255:0]       target_i,
    input  logic               hit_ack_i,
    output logic               checked_o,
    output logic               hit_valid_o,
    output logic [NONCE_W-1:0] hit_nonce_o,
    output logic [255:0]       hit_digest_o,
    output logic [MISS_W-1:0]  missed_o
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Nonce tagging
    logic [NONCE_W-1:0] nonce_q, nonce_d, nonce_tag;

    always_comb begin
        nonce_tag = newblock_i ? '0 : nonce_q;
        nonce_d   = valid_i ? nonce_tag + 1'b1 : nonce_q;
    end

    // Stage 1: IV addition
    logic [255:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 8; i++) begin
            sum_d[255-32*i -: 32] = instate[255-32*i -: 32]
                                  + IV[255-32*i -: 32];
        end
    end

    logic               s1_valid_q;
    logic [255:0]       s1_d_q;
    logic [255:0]       s1_tgt_q;
    logic [NONCE_W-1:0] s1_nonce_q;

    // Stage 2: split 256-bit compare into two 128-bit halves
    logic [255:0] dle;
    logic         up_lt_d, up_eq_d, lo_le_d;

    always_comb begin
        dle = '0;
        // word 7 lands in the MSBs, word 0 in the LSBs
        for (int i = 0; i < 8; i++) begin
            dle[32*i +: 32] = bswap(s1_d_q[255-32*i -: 32]);
        end
        up_lt_d = dle[255:128] <  s1_tgt_q[255:128];
        up_eq_d = dle[255:128] == s1_tgt_q[255:128];
        lo_le_d = dle[127:0]   <= s1_tgt_q[127:0];
    end

    logic               s2_valid_q;
    logic [255:0]       s2_d_q;
    logic [NONCE_W-1:0] s2_nonce_q;
    logic               s2_up_lt_q, s2_up_eq_q, s2_lo_le_q;

    // Stage 3: pass decision
    logic pass_d;

    always_comb begin
        pass_d = s2_up_lt_q | (s2_up_eq_q & s2_lo_le_q);
    end

    logic               s3_valid_q;
    logic               s3_pass_q;
    logic [255:0]       s3_d_q;
    logic [NONCE_W-1:0] s3_nonce_q;

    // Capture register next state
    logic               hit_valid_q, hit_valid_d;
    logic [NONCE_W-1:0] hit_nonce_q, hit_nonce_d;
    logic [255:0]       hit_digest_q, hit_digest_d;
    logic [MISS_W-1:0]  missed_q, missed_d;
    logic               checked_q;

    always_comb begin
        hit_valid_d  = hit_valid_q;
        hit_nonce_d  = hit_nonce_q;
        hit_digest_d = hit_digest_q;
        missed_d     = missed_q;
        if (s3_valid_q && s3_pass_q) begin
            if (!hit_valid_q || hit_ack_i) begin
                hit_valid_d  = 1'b1;
                hit_nonce_d  = s3_nonce_q;
                hit_digest_d = s3_d_q;
            end else if (missed_q != '1) begin
                missed_d = missed_q + 1'b1;
            end
        end else if (hit_ack_i) begin
            hit_valid_d = 1'b0;
        end
    end

    // Control state with reset
    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_q      <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            checked_q    <= 1'b0;
            hit_valid_q  <= 1'b0;
            hit_nonce_q  <= '0;
            hit_digest_q <= '0;
            missed_q     <= '0;
        end else begin
            nonce_q      <= nonce_d;
            s1_valid_q   <= valid_i;
            s2_valid_q   <= s1_valid_q;
            s3_valid_q   <= s2_valid_q;
            checked_q    <= s3_valid_q;
            hit_valid_q  <= hit_valid_d;
            hit_nonce_q  <= hit_nonce_d;
            hit_digest_q <= hit_digest_d;
            missed_q     <= missed_d;
        end
    end

    // Stage data needs no reset; the valid bits qualify it
    always_ff @(posedge clk) begin
        s1_d_q     <= sum_d;
        s1_tgt_q   <= target_i;
        s1_nonce_q <= nonce_tag;
        s2_d_q     <= s1_d_q;
        s2_nonce_q <= s1_nonce_q;
        s2_up_lt_q <= up_lt_d;
        s2_up_eq_q <= up_eq_d;
        s2_lo_le_q <= lo_le_d;
        s3_pass_q  <= pass_d;
        s3_d_q     <= s2_d_q;
        s3_nonce_q <= s2_nonce_q;
    end

    assign checked_o    = checked_q;
    assign hit_valid_o  = hit_valid_q;
    assign hit_nonce_o  = hit_nonce_q;
    assign hit_digest_o = hit_digest_q;
    assign missed_o     = missed_q;

endmodule

// File: tb/tb_sha_last_digest_checker.sv
// Directed bench for sha_last_digest_checker.
// Ports of the DUT are all driven/observed here.
module tb_sha_last_digest_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] instate;
    logic         valid_i;
    logic         newblock_i;
    logic [255:0] target_i;
    logic         hit_ack_i;
    logic         checked_o;
    logic         hit_valid_o;
    logic [31:0]  hit_nonce_o;
    logic [255:0] hit_digest_o;
    logic [7:0]   missed_o;

    sha_last_digest_checker #(.NONCE_W(32), .MISS_W(8)) dut (
        .clk(clk), .rst(rst), .instate(instate), .valid_i(valid_i),
        .newblock_i(newblock_i), .target_i(target_i),
        .hit_ack_i(hit_ack_i), .checked_o(checked_o),
        .hit_valid_o(hit_valid_o), .hit_nonce_o(hit_nonce_o),
        .hit_digest_o(hit_digest_o), .missed_o(missed_o)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IVC = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    // instate whose IV sum is all zero
    localparam logic [255:0] NEG_IV = {
        32'h95f61999, 32'h4498517b, 32'hc3910c8e, 32'h5ab00ac6,
        32'haef1ad81, 32'h64fa9774, 32'he07c2655, 32'ha41f32e7
    };
    // little-endian digest of the plain IV
    localparam logic [255:0] IV_LE = {
        32'h19cde05b, 32'habd9831f, 32'h8c68059b, 32'h7f520e51,
        32'h3af54fa5, 32'h72f36e3c, 32'h85ae67bb, 32'h67e6096a
    };
    localparam logic [255:0] ONES = '1;

    int passed = 0;
    int total  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one hash and return just after its result edge
    task automatic run_hash(input logic [255:0] st,
                            input logic [255:0] tg, input logic nb);
        instate    = st;
        target_i   = tg;
        valid_i    = 1'b1;
        newblock_i = nb;
        tick();
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic clear_hit();
        hit_ack_i = 1'b1;
        tick();
        hit_ack_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        instate    = '0;
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        target_i   = '0;
        hit_ack_i  = 1'b0;
        tick();
        tick();
        chk("rst_checked", checked_o, 0);
        chk("rst_hv", hit_valid_o, 0);
        chk("rst_nonce", hit_nonce_o, 0);
        chk("rst_digest", hit_digest_o, 0);
        chk("rst_missed", missed_o, 0);
        rst = 1'b0;

        // 1: latency and IV digest
        instate    = '0;
        target_i   = ONES;
        valid_i    = 1'b1;
        newblock_i = 1'b1;
        tick();
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        tick();
        chk("t1_e1_checked", checked_o, 0);
        tick();
        chk("t1_e2_checked", checked_o, 0);
        tick();
        chk("t1_checked", checked_o, 1);
        chk("t1_hv", hit_valid_o, 1);
        chk("t1_digest", hit_digest_o, IVC);
        chk("t1_nonce", hit_nonce_o, 0);
        tick();
        chk("t1_pulse_end", checked_o, 0);
        chk("t1_held", hit_valid_o, 1);
        clear_hit();
        chk("t1_ack_clr", hit_valid_o, 0);

        // 2: d[7]=0 against 2^224-1 and 2^223-1
        run_hash({224'h0, 32'ha41f32e7}, {32'h0, {224{1'b1}}}, 1'b1);
        chk("t2_hit_hv", hit_valid_o, 1);
        chk("t2_hit_dig", hit_digest_o, {IVC[255:32], 32'h0});
        clear_hit();
        run_hash({224'h0, 32'ha41f32e7}, {33'h0, {223{1'b1}}}, 1'b1);
        chk("t2_miss_chk", checked_o, 1);
        chk("t2_miss_hv", hit_valid_o, 0);

        // equality and target-zero boundaries
        run_hash('0, IV_LE, 1'b1);
        chk("eq_hit", hit_valid_o, 1);
        clear_hit();
        run_hash('0, IV_LE - 256'd1, 1'b1);
        chk("eq_m1_miss", hit_valid_o, 0);
        run_hash('0, '0, 1'b1);
        chk("t0_nz_miss", hit_valid_o, 0);
        run_hash(NEG_IV, '0, 1'b1);
        chk("t0_zero_hit", hit_valid_o, 1);
        chk("t0_zero_dig", hit_digest_o, 0);
        clear_hit();

        // 3: five back-to-back with ack held
        instate   = '0;
        target_i  = ONES;
        hit_ack_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            valid_i    = (k < 5);
            newblock_i = (k == 0);
            tick();
            if (k >= 3) begin
                chk("t3_checked", checked_o, 1);
                chk("t3_nonce", hit_nonce_o, 256'(k - 3));
            end
        end
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        tick();
        chk("t3_done", checked_o, 0);
        chk("t3_ack_clr", hit_valid_o, 0);
        chk("t3_missed", missed_o, 0);
        hit_ack_i = 1'b0;

        // 5: ack coincides with new hit
        valid_i    = 1'b1;
        newblock_i = 1'b1;
        tick();
        newblock_i = 1'b0;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        chk("t5_first_hv", hit_valid_o, 1);
        chk("t5_first_n", hit_nonce_o, 0);
        hit_ack_i = 1'b1;
        tick();
        hit_ack_i = 1'b0;
        chk("t5_hv", hit_valid_o, 1);
        chk("t5_nonce", hit_nonce_o, 1);
        chk("t5_missed", missed_o, 0);
        tick();
        chk("t5_hold_n", hit_nonce_o, 1);
        clear_hit();
        chk("t5_clr", hit_valid_o, 0);

        // 4: overflow saturates missed_o
        for (int k = 0; k < 305; k++) begin
            valid_i    = (k < 302);
            newblock_i = (k == 0);
            tick();
            if (k == 4) chk("t4_m1", missed_o, 1);
        end
        valid_i    = 1'b0;
        newblock_i = 1'b0;
        chk("t4_missed", missed_o, 255);
        chk("t4_hv", hit_valid_o, 1);
        chk("t4_nonce", hit_nonce_o, 0);
        chk("t4_digest", hit_digest_o, IVC);
        run_hash('0, ONES, 1'b0);
        chk("t4_sat", missed_o, 255);

        // 6: reset one cycle after a passing hash
        valid_i    = 1'b1;
        newblock_i = 1'b0;
        tick();
        valid_i = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_hv", hit_valid_o, 0);
        chk("t6_missed", missed_o, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_no_chk", checked_o, 0);
            chk("t6_no_hit", hit_valid_o, 0);
        end
        run_hash('0, ONES, 1'b0);
        chk("t6_post_chk", checked_o, 1);
        chk("t6_post_nonce", hit_nonce_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
